// File: rtl/alu_operand_stage_pkg.sv
// Shared instruction-set definitions: data/immediate widths, opcodes, flags
// and the operand-stage state encoding.
package InstructionSetPkg;

  localparam int DataWidth       = 8;
  localparam int ImmediateWidth  = 4;
  localparam int DefaultRegCount = 8;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpMove = 4'h1,
    OpAdd  = 4'h2,
    OpAdc  = 4'h3,
    OpSub  = 4'h4,
    OpSbc  = 4'h5,
    OpAnd  = 4'h6,
    OpOr   = 4'h7,
    OpXor  = 4'h8,
    OpLil  = 4'h9,
    OpLiu  = 4'hA
  } eOperation;

  localparam eOperation DefaultOperation = OpNop;

  typedef struct packed {
    logic carry;
    logic zero;
  } sFlags;

  localparam sFlags FlagsClear = '{carry: 1'b0, zero: 1'b0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } eStageState;

endpackage

// File: rtl/alu_operand_stage_register_file.sv
// General register file: operand read port (source and destination), a debug
// read port and a single synchronous write port.
module register_file
  import InstructionSetPkg::*;
#(
  parameter  int RegCount  = DefaultRegCount,
  localparam int AddrWidth = $clog2(RegCount)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AddrWidth-1:0] src_addr,
  input  logic [AddrWidth-1:0] dest_addr,
  output logic [DataWidth-1:0] src_data,
  output logic [DataWidth-1:0] dest_data,
  input  logic [AddrWidth-1:0] dbg_addr,
  output logic [DataWidth-1:0] dbg_data,
  input  logic                 write_en,
  input  logic [AddrWidth-1:0] write_addr,
  input  logic [DataWidth-1:0] write_data
);

  logic [DataWidth-1:0] regs_r [RegCount];

  // Storage array: cleared by reset, written one entry per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RegCount; i++) begin
        regs_r[i] <= {DataWidth{1'b0}};
      end
    end else if (write_en) begin
      regs_r[write_addr] <= write_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Reads see the array directly, so a write is visible from its own edge on.
  assign src_data  = regs_r[src_addr];
  assign dest_data = regs_r[dest_addr];
  assign dbg_data  = regs_r[dbg_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Four-phase operand stage: accepts an instruction, fetches operands, presents
// them to an external ALU and writes the result and flags back.
module alu_operand_stage
  import InstructionSetPkg::*;
#(
  parameter  int RegCount  = DefaultRegCount,
  localparam int AddrWidth = $clog2(RegCount)
) (
  input  logic                      Clock,
  input  logic                      nReset,
  input  logic                      InstrValid,
  output logic                      InstrReady,
  input  eOperation                 InstrOp,
  input  logic [AddrWidth-1:0]      InstrDest,
  input  logic [AddrWidth-1:0]      InstrSrc,
  input  logic [ImmediateWidth-1:0] InstrImm,
  output eOperation                 AluOperation,
  output logic [DataWidth-1:0]      AluInSrc,
  output logic [DataWidth-1:0]      AluInDest,
  output logic [ImmediateWidth-1:0] AluInImm,
  output sFlags                     AluInFlags,
  input  logic [DataWidth-1:0]      AluOutDest,
  input  sFlags                     AluOutFlags,
  output logic                      Done,
  output sFlags                     Flags,
  input  logic [AddrWidth-1:0]      DbgAddr,
  output logic [DataWidth-1:0]      DbgData
);

  eStageState                state_r;
  eStageState                state_next_s;
  logic                      accept_s;
  logic                      write_en_s;
  logic                      ready_r;
  logic                      done_r;

  eOperation                 instr_op_r;
  logic [AddrWidth-1:0]      instr_dest_r;
  logic [AddrWidth-1:0]      instr_src_r;
  logic [ImmediateWidth-1:0] instr_imm_r;

  eOperation                 alu_op_r;
  logic [DataWidth-1:0]      src_operand_r;
  logic [DataWidth-1:0]      dest_operand_r;
  logic [ImmediateWidth-1:0] alu_imm_r;

  logic [DataWidth-1:0]      result_r;
  sFlags                     result_flags_r;
  sFlags                     flags_r;

  logic [DataWidth-1:0]      rf_src_data_s;
  logic [DataWidth-1:0]      rf_dest_data_s;

  // Next-state decode; only IDLE looks at InstrValid.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (InstrValid) begin
          accept_s     = 1'b1;
          state_next_s = READ;
        end else begin
          state_next_s = IDLE;
        end
      end
      READ:    state_next_s = EXEC;
      EXEC:    state_next_s = WRITE;
      WRITE:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus registered handshake outputs derived from next state.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s == IDLE);
      done_r  <= (state_next_s == WRITE);
    end
  end

  // Instruction fields are captured only on an accepted handshake.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      instr_op_r   <= DefaultOperation;
      instr_dest_r <= {AddrWidth{1'b0}};
      instr_src_r  <= {AddrWidth{1'b0}};
      instr_imm_r  <= {ImmediateWidth{1'b0}};
    end else if (accept_s) begin
      instr_op_r   <= InstrOp;
      instr_dest_r <= InstrDest;
      instr_src_r  <= InstrSrc;
      instr_imm_r  <= InstrImm;
    end else begin
      instr_op_r   <= instr_op_r;
      instr_dest_r <= instr_dest_r;
      instr_src_r  <= instr_src_r;
      instr_imm_r  <= instr_imm_r;
    end
  end

  // Operand registers double as the ALU inputs, so they hold outside EXEC.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      alu_op_r       <= DefaultOperation;
      src_operand_r  <= {DataWidth{1'b0}};
      dest_operand_r <= {DataWidth{1'b0}};
      alu_imm_r      <= {ImmediateWidth{1'b0}};
    end else if (state_r == READ) begin
      alu_op_r       <= instr_op_r;
      src_operand_r  <= rf_src_data_s;
      dest_operand_r <= rf_dest_data_s;
      alu_imm_r      <= instr_imm_r;
    end else begin
      alu_op_r       <= alu_op_r;
      src_operand_r  <= src_operand_r;
      dest_operand_r <= dest_operand_r;
      alu_imm_r      <= alu_imm_r;
    end
  end

  // ALU result is sampled at the end of EXEC; flags commit at the end of WRITE.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      result_r       <= {DataWidth{1'b0}};
      result_flags_r <= FlagsClear;
      flags_r        <= FlagsClear;
    end else begin
      if (state_r == EXEC) begin
        result_r       <= AluOutDest;
        result_flags_r <= AluOutFlags;
      end else begin
        result_r       <= result_r;
        result_flags_r <= result_flags_r;
      end
      if (state_r == WRITE) begin
        flags_r <= result_flags_r;
      end else begin
        flags_r <= flags_r;
      end
    end
  end

  assign write_en_s = (state_r == WRITE);

  register_file #(
    .RegCount (RegCount)
  ) u_register_file (
    .clk        (Clock),
    .rst_n      (nReset),
    .src_addr   (instr_src_r),
    .dest_addr  (instr_dest_r),
    .src_data   (rf_src_data_s),
    .dest_data  (rf_dest_data_s),
    .dbg_addr   (DbgAddr),
    .dbg_data   (DbgData),
    .write_en   (write_en_s),
    .write_addr (instr_dest_r),
    .write_data (result_r)
  );

  assign InstrReady   = ready_r;
  assign Done         = done_r;
  assign AluOperation = alu_op_r;
  assign AluInSrc     = src_operand_r;
  assign AluInDest    = dest_operand_r;
  assign AluInImm     = alu_imm_r;
  assign AluInFlags   = flags_r;
  assign Flags        = flags_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and randomized bench for alu_operand_stage with a behavioural ALU
// and an architectural register/flag reference model.
module tb_alu_operand_stage;
  import InstructionSetPkg::*;

  localparam int RegCount  = 8;
  localparam int AddrWidth = 3;
  localparam int FlagBits  = $bits(sFlags);

  logic                      Clock = 1'b0;
  logic                      nReset;
  logic                      InstrValid;
  logic                      InstrReady;
  eOperation                 InstrOp;
  logic [AddrWidth-1:0]      InstrDest;
  logic [AddrWidth-1:0]      InstrSrc;
  logic [ImmediateWidth-1:0] InstrImm;
  eOperation                 AluOperation;
  logic [DataWidth-1:0]      AluInSrc;
  logic [DataWidth-1:0]      AluInDest;
  logic [ImmediateWidth-1:0] AluInImm;
  sFlags                     AluInFlags;
  logic [DataWidth-1:0]      AluOutDest;
  sFlags                     AluOutFlags;
  logic                      Done;
  sFlags                     Flags;
  logic [AddrWidth-1:0]      DbgAddr;
  logic [DataWidth-1:0]      DbgData;

  logic [DataWidth+FlagBits-1:0] alu_bus;
  logic [DataWidth-1:0]          ref_regs [RegCount];
  sFlags                         ref_flags;
  int                            vectors     = 0;
  int                            miscompares = 0;

  always #5 Clock = ~Clock;

  alu_operand_stage #(.RegCount(RegCount)) dut (
    .Clock(Clock), .nReset(nReset),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .InstrOp(InstrOp), .InstrDest(InstrDest), .InstrSrc(InstrSrc), .InstrImm(InstrImm),
    .AluOperation(AluOperation), .AluInSrc(AluInSrc), .AluInDest(AluInDest),
    .AluInImm(AluInImm), .AluInFlags(AluInFlags),
    .AluOutDest(AluOutDest), .AluOutFlags(AluOutFlags),
    .Done(Done), .Flags(Flags), .DbgAddr(DbgAddr), .DbgData(DbgData)
  );

  // Behavioural ALU: returns {result, flags}; unknown opcodes give zero and pass flags.
  function automatic logic [DataWidth+FlagBits-1:0] ref_alu(
      input eOperation op, input logic [DataWidth-1:0] d, input logic [DataWidth-1:0] s,
      input logic [ImmediateWidth-1:0] imm, input sFlags f);
    logic [DataWidth:0]   w;
    logic [DataWidth-1:0] r;
    sFlags                nf;
    nf = f;
    r  = d;
    w  = {(DataWidth+1){1'b0}};
    case (op)
      OpNop:  r = d;
      OpMove: begin r = s; nf.zero = (r == {DataWidth{1'b0}}); end
      OpAdd:  w = {1'b0, d} + {1'b0, s};
      OpAdc:  w = {1'b0, d} + {1'b0, s} + {{DataWidth{1'b0}}, f.carry};
      OpSub:  w = {1'b0, d} - {1'b0, s};
      OpSbc:  w = {1'b0, d} - {1'b0, s} - {{DataWidth{1'b0}}, f.carry};
      OpAnd:  begin r = d & s; nf.zero = (r == {DataWidth{1'b0}}); end
      OpOr:   begin r = d | s; nf.zero = (r == {DataWidth{1'b0}}); end
      OpXor:  begin r = d ^ s; nf.zero = (r == {DataWidth{1'b0}}); end
      OpLil:  r = {d[DataWidth-1:ImmediateWidth], imm};
      OpLiu:  r = {imm, d[DataWidth-ImmediateWidth-1:0]};
      default: begin r = {DataWidth{1'b0}}; nf = f; end
    endcase
    if (op == OpAdd || op == OpAdc || op == OpSub || op == OpSbc) begin
      r        = w[DataWidth-1:0];
      nf.carry = w[DataWidth];
      nf.zero  = (r == {DataWidth{1'b0}});
    end
    return {r, nf};
  endfunction

  always_comb alu_bus = ref_alu(AluOperation, AluInDest, AluInSrc, AluInImm, AluInFlags);
  assign AluOutDest  = alu_bus[DataWidth+FlagBits-1:FlagBits];
  assign AluOutFlags = sFlags'(alu_bus[FlagBits-1:0]);

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic check_all_regs(input string tag);
    for (int r = 0; r < RegCount; r++) begin
      DbgAddr = AddrWidth'(r);
      #1;
      check(tag, 32'(DbgData), 32'(ref_regs[r]));
    end
    check({tag, "_flags"}, 32'(Flags), 32'(ref_flags));
    @(negedge Clock);
  endtask

  task automatic reset_model();
    for (int r = 0; r < RegCount; r++) ref_regs[r] = {DataWidth{1'b0}};
    ref_flags = FlagsClear;
  endtask

  // Issue one instruction from a negedge, check Done latency and writeback.
  task automatic run_instr(input eOperation op, input logic [AddrWidth-1:0] dest,
                           input logic [AddrWidth-1:0] src,
                           input logic [ImmediateWidth-1:0] imm, input bit junk);
    logic [DataWidth+FlagBits-1:0] exp_bus;
    int waited;
    int lat;
    waited = 0;
    while (InstrReady !== 1'b1 && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    check("ready_before_issue", 32'(InstrReady), 32'(1'b1));
    exp_bus    = ref_alu(op, ref_regs[dest], ref_regs[src], imm, ref_flags);
    InstrValid = 1'b1;
    InstrOp    = op;
    InstrDest  = dest;
    InstrSrc   = src;
    InstrImm   = imm;
    @(posedge Clock);
    @(negedge Clock);
    if (junk) begin
      InstrOp   = eOperation'(4'($urandom_range(0, 15)));
      InstrDest = AddrWidth'($urandom_range(0, RegCount - 1));
      InstrSrc  = AddrWidth'($urandom_range(0, RegCount - 1));
      InstrImm  = ImmediateWidth'($urandom_range(0, 15));
    end else begin
      InstrValid = 1'b0;
    end
    lat = 1;
    while (Done !== 1'b1 && lat < 8) begin
      @(negedge Clock);
      lat++;
    end
    check("done_latency", 32'(lat), 32'd3);
    ref_regs[dest] = exp_bus[DataWidth+FlagBits-1:FlagBits];
    ref_flags      = sFlags'(exp_bus[FlagBits-1:0]);
    @(negedge Clock);
    InstrValid = 1'b0;
    DbgAddr    = dest;
    #1;
    check("writeback", 32'(DbgData), 32'(ref_regs[dest]));
    check("flags", 32'(Flags), 32'(ref_flags));
    check("alu_in_flags", 32'(AluInFlags), 32'(ref_flags));
    check("done_one_cycle", 32'(Done), 32'(1'b0));
  endtask

  initial begin
    int accepts;
    int dones;
    int last_cyc;
    bit saw_done;
    logic [DataWidth+FlagBits-1:0] tp_bus;
    eOperation tp_op;
    logic [AddrWidth-1:0] tp_d;
    logic [AddrWidth-1:0] tp_s;
    logic [ImmediateWidth-1:0] tp_i;

    nReset     = 1'b0;
    InstrValid = 1'b0;
    InstrOp    = OpNop;
    InstrDest  = {AddrWidth{1'b0}};
    InstrSrc   = {AddrWidth{1'b0}};
    InstrImm   = {ImmediateWidth{1'b0}};
    DbgAddr    = {AddrWidth{1'b0}};
    reset_model();
    repeat (3) @(negedge Clock);

    // Reset state and debug poll
    check("reset_ready", 32'(InstrReady), 32'(1'b1));
    check("reset_done", 32'(Done), 32'(1'b0));
    check("reset_aluop", 32'(AluOperation), 32'(DefaultOperation));
    check_all_regs("reset_reg");
    nReset = 1'b1;

    // Load-immediate pair, first accept right after reset release
    run_instr(OpLil, 3'd1, 3'd0, 4'b0111, 1'b0);
    DbgAddr = 3'd1; #1;
    check("lil_r1", 32'(DbgData), 32'h07);
    run_instr(OpLiu, 3'd1, 3'd0, 4'hA, 1'b0);
    DbgAddr = 3'd1; #1;
    check("liu_r1", 32'(DbgData), 32'hA7);

    // R2=5, R3=3, carry=1, then ADC and SUB
    run_instr(OpLil, 3'd2, 3'd0, 4'd5, 1'b0);
    run_instr(OpLil, 3'd3, 3'd0, 4'd3, 1'b0);
    run_instr(OpLil, 3'd7, 3'd0, 4'hF, 1'b0);
    run_instr(OpLiu, 3'd7, 3'd0, 4'hF, 1'b0);
    run_instr(OpLil, 3'd0, 3'd0, 4'd1, 1'b0);
    run_instr(OpAdd, 3'd7, 3'd0, 4'd0, 1'b0);
    check("carry_set", 32'(Flags.carry), 32'(1'b1));
    run_instr(OpAdc, 3'd2, 3'd3, 4'd0, 1'b0);
    DbgAddr = 3'd2; #1;
    check("adc_r2", 32'(DbgData), 32'd9);
    check("adc_carry", 32'(Flags.carry), 32'(1'b0));
    check("adc_zero", 32'(Flags.zero), 32'(1'b0));
    run_instr(OpSub, 3'd2, 3'd2, 4'd0, 1'b0);
    DbgAddr = 3'd2; #1;
    check("sub_r2", 32'(DbgData), 32'd0);
    check("sub_zero", 32'(Flags.zero), 32'(1'b1));
    check_all_regs("after_adc");

    // Back-to-back with InstrValid held high
    accepts  = 0;
    dones    = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (Done === 1'b1) dones++;
      if (InstrReady === 1'b1 && accepts < 6) begin
        if (last_cyc >= 0) check("accept_gap", 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
        case ($urandom_range(0, 3))
          0:       tp_op = OpLil;
          1:       tp_op = OpAdd;
          2:       tp_op = OpXor;
          default: tp_op = OpLiu;
        endcase
        tp_d       = AddrWidth'($urandom_range(0, RegCount - 1));
        tp_s       = AddrWidth'($urandom_range(0, RegCount - 1));
        tp_i       = ImmediateWidth'($urandom_range(1, 15));
        tp_bus     = ref_alu(tp_op, ref_regs[tp_d], ref_regs[tp_s], tp_i, ref_flags);
        ref_regs[tp_d] = tp_bus[DataWidth+FlagBits-1:FlagBits];
        ref_flags  = sFlags'(tp_bus[FlagBits-1:0]);
        InstrValid = 1'b1;
        InstrOp    = tp_op;
        InstrDest  = tp_d;
        InstrSrc   = tp_s;
        InstrImm   = tp_i;
        accepts++;
      end else if (InstrReady === 1'b1) begin
        InstrValid = 1'b0;
      end
      @(negedge Clock);
    end
    InstrValid = 1'b0;
    check("stream_accepts", 32'(accepts), 32'd6);
    check("stream_dones", 32'(dones), 32'd6);
    check_all_regs("stream_reg");

    // Reset during EXEC of MOVE R4 <- R5
    run_instr(OpLil, 3'd5, 3'd0, 4'd2, 1'b0);
    run_instr(OpLiu, 3'd5, 3'd0, 4'd1, 1'b0);
    InstrValid = 1'b1;
    InstrOp    = OpMove;
    InstrDest  = 3'd4;
    InstrSrc   = 3'd5;
    InstrImm   = 4'd0;
    @(posedge Clock);
    @(negedge Clock);
    InstrValid = 1'b0;
    @(negedge Clock);
    check("exec_op", 32'(AluOperation), 32'(OpMove));
    check("exec_src", 32'(AluInSrc), 32'h12);
    nReset = 1'b0;
    #1;
    check("abort_ready_async", 32'(InstrReady), 32'(1'b1));
    check("abort_done_async", 32'(Done), 32'(1'b0));
    check("abort_aluop_async", 32'(AluOperation), 32'(DefaultOperation));
    @(negedge Clock);
    nReset = 1'b1;
    reset_model();
    saw_done = 1'b0;
    @(negedge Clock);
    check("abort_idle_next", 32'(InstrReady), 32'(1'b1));
    for (int k = 0; k < 4; k++) begin
      if (Done === 1'b1) saw_done = 1'b1;
      @(negedge Clock);
    end
    check("abort_no_done", 32'(saw_done), 32'(1'b0));
    DbgAddr = 3'd4; #1;
    check("abort_r4", 32'(DbgData), 32'd0);
    check_all_regs("abort_reg");

    // Unknown opcode on R6 = 0x55 with carry and zero both set
    run_instr(OpLil, 3'd7, 3'd0, 4'hF, 1'b0);
    run_instr(OpLiu, 3'd7, 3'd0, 4'hF, 1'b0);
    run_instr(OpLil, 3'd0, 3'd0, 4'd1, 1'b0);
    run_instr(OpAdd, 3'd7, 3'd0, 4'd0, 1'b0);
    run_instr(OpLil, 3'd6, 3'd0, 4'd5, 1'b0);
    run_instr(OpLiu, 3'd6, 3'd0, 4'd5, 1'b0);
    DbgAddr = 3'd6; #1;
    check("preload_r6", 32'(DbgData), 32'h55);
    run_instr(eOperation'(4'hE), 3'd6, 3'd1, 4'd9, 1'b0);
    DbgAddr = 3'd6; #1;
    check("unknown_r6", 32'(DbgData), 32'd0);
    check("unknown_flags", 32'(Flags), 32'(2'b11));

    // Randomized instructions, some with InstrValid held during busy states
    for (int n = 0; n < 40; n++) begin
      run_instr(eOperation'(4'($urandom_range(0, 15))),
                AddrWidth'($urandom_range(0, RegCount - 1)),
                AddrWidth'($urandom_range(0, RegCount - 1)),
                ImmediateWidth'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge Clock);
    end
    check_all_regs("random_reg");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
